// File: rtl/test_monitor_pkg.sv
// test_monitor_pkg: shared types and constants for the CI test monitor.
//   state_e      monitor FSM states (HOLD, RUN, DONE)
//   CYCLE_W      width of the RUN cycle counter
//   CYCLE_SAT    saturation value of the RUN cycle counter
//   cnt_width()  counter width needed to count up to a given value
package test_monitor_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned CYCLE_W = 32;
    localparam logic [CYCLE_W-1:0] CYCLE_SAT = '1;

    // Bits needed to hold the values 0..max_val (at least 1).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 32'd2) ? 32'd1 : $clog2(max_val + 32'd1);
    endfunction

endpackage

// File: rtl/test_monitor_if.sv
// test_monitor_if: bundle between the monitor and the attached test harnesses.
//   test_reset  monitor -> tests  synchronous active-high harness reset
//   fail        tests -> monitor  per-test fail flags
//   finish      tests -> monitor  per-test finish flags
//   fail_vec, finish_vec, done, pass, timeout, cycles  monitor verdict outputs
// Modports: master = monitor side, slave = harness / simulation-top side.
interface test_monitor_if #(
    parameter int unsigned NUM_TESTS = 8
);
    logic                                 test_reset;
    logic [NUM_TESTS-1:0]                 fail;
    logic [NUM_TESTS-1:0]                 finish;
    logic [NUM_TESTS-1:0]                 fail_vec;
    logic [NUM_TESTS-1:0]                 finish_vec;
    logic                                 done;
    logic                                 pass;
    logic                                 timeout;
    logic [test_monitor_pkg::CYCLE_W-1:0] cycles;

    modport master (
        output test_reset, fail_vec, finish_vec, done, pass, timeout, cycles,
        input  fail, finish
    );

    modport slave (
        input  test_reset, fail_vec, finish_vec, done, pass, timeout, cycles,
        output fail, finish
    );
endinterface

// File: rtl/test_monitor_watchdog.sv
// test_monitor_watchdog: loadable up-counter that saturates at limit_i.
//   clk_i, rst_ni   clock, async active-low reset
//   clear_i         synchronous clear to 0 (highest priority)
//   load_i          synchronous load of load_val_i
//   en_i            count enable
//   limit_i         terminal count
//   expired_c_o     combinational: the current enabled edge brings count to limit_i
module test_monitor_watchdog #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             expired_c_o
);
    logic [WIDTH-1:0] count_q, count_d;

    // Next count: clear, then load, then saturating increment.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != limit_i)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flags the edge that reaches the limit so the owner can act on that same edge.
    assign expired_c_o = en_i && !clear_i && !load_i && (count_q == (limit_i - WIDTH'(1)));
endmodule

// File: rtl/test_monitor.sv
// test_monitor: holds the test harnesses in reset, collects their fail/finish
// flags, enforces a cycle-budget watchdog and produces a sticky verdict.
//   clock_i   clock, all logic on posedge
//   reset_i   asynchronous active-low monitor reset
//   bus       test_monitor_if.master (test_reset out, fail/finish in, verdict out)
// Optional: define TEST_MONITOR_DISPLAY_EN for simulation summary/fail prints.
module test_monitor
    import test_monitor_pkg::*;
#(
    parameter int unsigned NUM_TESTS    = 8,
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic           clock_i,
    input  logic           reset_i,
    test_monitor_if.master bus
);
    localparam int unsigned HOLD_W = cnt_width(RESET_CYCLES);
    localparam int unsigned WD_W   = cnt_width(TIMEOUT);

    state_e               state_q, state_d;
    logic                 test_reset_q, test_reset_d;
    logic [NUM_TESTS-1:0] fail_vec_q, fail_vec_d;
    logic [NUM_TESTS-1:0] finish_vec_q, finish_vec_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 timeout_q, timeout_d;
    logic [CYCLE_W-1:0]   cycles_q, cycles_d;

    logic [NUM_TESTS-1:0] fail_clean, finish_clean;
    logic                 hold_en, hold_exp;
    logic                 wd_en, wd_clr, wd_exp;

    test_monitor_watchdog #(.WIDTH(HOLD_W)) u_hold_cnt (
        .clk_i       (clock_i),
        .rst_ni      (reset_i),
        .clear_i     (1'b0),
        .load_i      (1'b0),
        .load_val_i  ('0),
        .en_i        (hold_en),
        .limit_i     (HOLD_W'(RESET_CYCLES)),
        .expired_c_o (hold_exp)
    );

    test_monitor_watchdog #(.WIDTH(WD_W)) u_run_wd (
        .clk_i       (clock_i),
        .rst_ni      (reset_i),
        .clear_i     (wd_clr),
        .load_i      (1'b0),
        .load_val_i  ('0),
        .en_i        (wd_en),
        .limit_i     (WD_W'(TIMEOUT)),
        .expired_c_o (wd_exp)
    );

    // Only a solid 1 counts as a flag; X/Z from a misbehaving harness reads as 0.
    always_comb begin
        fail_clean   = '0;
        finish_clean = '0;
        for (int i = 0; i < int'(NUM_TESTS); i++) begin
            fail_clean[i]   = (bus.fail[i] === 1'b1);
            finish_clean[i] = (bus.finish[i] === 1'b1);
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        test_reset_d = test_reset_q;
        fail_vec_d   = fail_vec_q;
        finish_vec_d = finish_vec_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        cycles_d     = cycles_q;
        hold_en      = 1'b0;
        wd_en        = 1'b0;
        wd_clr       = 1'b0;
        case (state_q)
            HOLD: begin
                test_reset_d = 1'b1;
                hold_en      = 1'b1;
                wd_clr       = 1'b1;
                if (hold_exp) begin
                    state_d      = RUN;
                    test_reset_d = 1'b0;
                end
            end
            RUN: begin
                wd_en        = 1'b1;
                fail_vec_d   = fail_vec_q | fail_clean;
                finish_vec_d = finish_vec_q | finish_clean;
                if (cycles_q != CYCLE_SAT) begin
                    cycles_d = cycles_q + CYCLE_W'(1);
                end
                // Exit tests use the updated vectors so same-cycle flags count.
                if ((&finish_vec_d) || (|fail_vec_d) || wd_exp) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = wd_exp;
                    pass_d    = (&finish_vec_d) && !(|fail_vec_d) && !wd_exp;
                end
            end
            DONE: begin
                test_reset_d = 1'b0;
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= HOLD;
            test_reset_q <= 1'b1;
            fail_vec_q   <= '0;
            finish_vec_q <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            cycles_q     <= '0;
        end else begin
            state_q      <= state_d;
            test_reset_q <= test_reset_d;
            fail_vec_q   <= fail_vec_d;
            finish_vec_q <= finish_vec_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            cycles_q     <= cycles_d;
        end
    end

    assign bus.test_reset = test_reset_q;
    assign bus.fail_vec   = fail_vec_q;
    assign bus.finish_vec = finish_vec_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.timeout    = timeout_q;
    assign bus.cycles     = cycles_q;

`ifdef TEST_MONITOR_DISPLAY_EN
    // Simulation-only reporting of first-seen fails and the final verdict.
    always @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(NUM_TESTS); i++) begin
                if (fail_vec_d[i] && !fail_vec_q[i]) begin
                    $display("test_monitor: test %0d failed at run cycle %0d", i, cycles_d);
                end
            end
            if ((state_q == RUN) && (state_d == DONE)) begin
                $display("test_monitor: verdict=%s cycles=%0d fail_vec=%h finish_vec=%h",
                         pass_d ? "passed" : (timeout_d ? "timeout" : "failed"),
                         cycles_d, fail_vec_d, finish_vec_d);
            end
        end
    end
`else
    // Reporting disabled; monitor logic above is unchanged.
`endif
endmodule

// File: tb/tb_test_monitor.sv
// tb_test_monitor: directed and randomized runs of test_monitor (2 tests,
// RESET_CYCLES=4, TIMEOUT=16) checked against a run-level reference model.
module tb_test_monitor;
    localparam int unsigned N  = 2;
    localparam int unsigned RC = 4;
    localparam int unsigned TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    test_monitor_if #(.NUM_TESTS(N)) bus ();

    test_monitor #(
        .NUM_TESTS    (N),
        .RESET_CYCLES (RC),
        .TIMEOUT      (TO)
    ) dut (
        .clock_i (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [N-1:0] stim_fail   [1:TO];
    logic [N-1:0] stim_finish [1:TO];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Run-level reference: first RUN cycle where all finished, any failed, or budget spent.
    function automatic void model(output int k, output logic [N-1:0] efv, output logic [N-1:0] efn);
        efv = '0;
        efn = '0;
        k   = int'(TO);
        for (int c = 1; c <= int'(TO); c++) begin
            efv = efv | stim_fail[c];
            efn = efn | stim_finish[c];
            if ((&efn) || (|efv) || (c == int'(TO))) begin
                k = c;
                break;
            end
        end
    endfunction

    task automatic clear_stim();
        for (int c = 1; c <= int'(TO); c++) begin
            stim_fail[c]   = '0;
            stim_finish[c] = '0;
        end
    endtask

    // Assert reset between clock edges and confirm outputs clear immediately.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, ".rst.test_reset"}, 64'(bus.test_reset), 64'd1);
        check({tag, ".rst.fail_vec"},   64'(bus.fail_vec),   64'd0);
        check({tag, ".rst.finish_vec"}, 64'(bus.finish_vec), 64'd0);
        check({tag, ".rst.done"},       64'(bus.done),       64'd0);
        check({tag, ".rst.pass"},       64'(bus.pass),       64'd0);
        check({tag, ".rst.timeout"},    64'(bus.timeout),    64'd0);
        check({tag, ".rst.cycles"},     64'(bus.cycles),     64'd0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, ".rst.held"}, 64'(bus.test_reset), 64'd1);
    endtask

    // Release reset and walk through HOLD while driving garbage flags.
    task automatic release_and_hold(input string tag);
        @(negedge clk);
        bus.fail   = '1;
        bus.finish = '1;
        rst_n      = 1'b1;
        for (int j = 1; j <= int'(RC); j++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold.test_reset"}, 64'(bus.test_reset), (j < int'(RC)) ? 64'd1 : 64'd0);
            check({tag, ".hold.fail_vec"},   64'(bus.fail_vec),   64'd0);
            check({tag, ".hold.done"},       64'(bus.done),       64'd0);
            if (j < int'(RC)) begin
                @(negedge clk);
                bus.fail   = N'($urandom) | N'(1);
                bus.finish = N'($urandom);
            end
        end
        check({tag, ".hold.finish_vec"}, 64'(bus.finish_vec), 64'd0);
        check({tag, ".hold.cycles"},     64'(bus.cycles),     64'd0);
    endtask

    task automatic run_case(input string tag);
        int           k;
        logic [N-1:0] efv, efn;
        logic         et, ep;
        model(k, efv, efn);
        et = (k == int'(TO));
        ep = (&efn) && !(|efv) && !et;
        release_and_hold(tag);
        for (int c = 1; c <= k; c++) begin
            @(negedge clk);
            bus.fail   = stim_fail[c];
            bus.finish = stim_finish[c];
            @(posedge clk);
            #1;
            check({tag, ".cycles"},     64'(bus.cycles),     64'(c));
            check({tag, ".done"},       64'(bus.done),       (c == k) ? 64'd1 : 64'd0);
            check({tag, ".test_reset"}, 64'(bus.test_reset), 64'd0);
        end
        check({tag, ".fail_vec"},   64'(bus.fail_vec),   64'(efv));
        check({tag, ".finish_vec"}, 64'(bus.finish_vec), 64'(efn));
        check({tag, ".pass"},       64'(bus.pass),       64'(ep));
        check({tag, ".timeout"},    64'(bus.timeout),    64'(et));
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            bus.fail   = N'($urandom);
            bus.finish = N'($urandom);
            @(posedge clk);
            #1;
            check({tag, ".frozen.done"},       64'(bus.done),       64'd1);
            check({tag, ".frozen.cycles"},     64'(bus.cycles),     64'(k));
            check({tag, ".frozen.fail_vec"},   64'(bus.fail_vec),   64'(efv));
            check({tag, ".frozen.finish_vec"}, 64'(bus.finish_vec), 64'(efn));
            check({tag, ".frozen.pass"},       64'(bus.pass),       64'(ep));
            check({tag, ".frozen.timeout"},    64'(bus.timeout),    64'(et));
        end
    endtask

    initial begin
        bus.fail   = '0;
        bus.finish = '0;
        do_reset("init");

        // Both tests finish on RUN cycle 3.
        clear_stim();
        stim_finish[3] = 2'b11;
        run_case("both_finish");

        // Test 0 fails on cycle 2, test 1 never finishes.
        do_reset("r1");
        clear_stim();
        stim_fail[2] = 2'b01;
        run_case("early_fail");

        // Nothing ever finishes: watchdog.
        do_reset("r2");
        clear_stim();
        run_case("no_finish");

        // All finish exactly on the expiry cycle.
        do_reset("r3");
        clear_stim();
        stim_finish[TO] = 2'b11;
        run_case("finish_at_expiry");

        // Fail and finish together on the expiry cycle.
        do_reset("r4");
        clear_stim();
        stim_finish[TO] = 2'b11;
        stim_fail[TO]   = 2'b10;
        run_case("fail_at_expiry");

        // Staggered finishes, one test with fail and finish on the same cycle.
        do_reset("r5");
        clear_stim();
        stim_finish[2] = 2'b01;
        stim_finish[5] = 2'b10;
        stim_fail[5]   = 2'b10;
        run_case("fail_with_finish");

        // Reset asserted mid-RUN, then reset in DONE with fail_vec=10, then a clean run.
        do_reset("r6");
        clear_stim();
        release_and_hold("partial");
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.fail   = '0;
            bus.finish = '0;
            @(posedge clk);
            #1;
            check("partial.done", 64'(bus.done), 64'd0);
        end
        do_reset("midrun");
        clear_stim();
        stim_fail[2] = 2'b10;
        run_case("fail_test1");
        do_reset("indone");
        clear_stim();
        stim_finish[1] = 2'b10;
        stim_finish[4] = 2'b01;
        run_case("rerun_pass");

        // Randomized runs.
        for (int r = 0; r < 25; r++) begin
            do_reset("rnd");
            for (int c = 1; c <= int'(TO); c++) begin
                stim_fail[c]   = ($urandom_range(0, 29) == 0) ? N'($urandom) : '0;
                stim_finish[c] = (r % 4 == 0) ? '0 : N'($urandom & $urandom & $urandom);
            end
            run_case($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no end of test, expected $finish before 2000000");
        $fatal(1);
    end
endmodule
